gb_oam_dma_arbiter: RTL

- Owns the single memory bus (address, data, write enable) between the dzcpu core and a Game Boy style OAM DMA engine.
- A CPU write to the DMA register (0xFF46) starts a copy of DMA_LEN bytes from {V,8'h00} to the OAM region at DEST_BASE.
- While the copy runs, the CPU is locked out of memory.
- Sits between the CPU memory port and the memory/IO decode.

---
 rtl/gb_oam_dma_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/gb_oam_dma_arbiter.sv
// Memory bus arbiter between the CPU port and a Game Boy style OAM DMA engine.
// A write to the DMA register copies DMA_LEN bytes from {page,8'h00} to DEST_BASE.
module gb_oam_dma_arbiter #(
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] DEST_BASE    = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [7:0]  OPEN_BUS     = 8'hFF
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    output logic [7:0]  oCpuData,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oMemWe,
    input  logic [7:0]  iMemData,
    output logic        oDmaActive
);

    localparam int unsigned IDX_W     = 8;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DMA_LEN - 1);
    localparam logic [7:0]       ECHO_BASE = 8'hE0;
    localparam logic [7:0]       ECHO_OFS  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         dma_reg_q, dma_reg_d;
    logic [7:0]         src_hi_q, src_hi_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         byte_q, byte_d;

    logic               reg_hit;
    logic               start;
    logic [7:0]         src_hi_remap;
    logic               dma_owns_bus;

    assign reg_hit      = (iCpuAddr == DMA_REG_ADDR);
    assign start        = iCpuWe && reg_hit;
    // Echo RAM (E000-FDFF) mirrors C000-DDFF
    assign src_hi_remap = (iCpuData >= ECHO_BASE) ? (iCpuData - ECHO_OFS) : iCpuData;
    // Reset forces pass-through even while the state register still holds a DMA state
    assign dma_owns_bus = iReset && (state_q != ST_IDLE);

    // State and datapath registers
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q   <= ST_IDLE;
            dma_reg_q <= 8'h00;
            src_hi_q  <= 8'h00;
            idx_q     <= '0;
            byte_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            dma_reg_q <= dma_reg_d;
            src_hi_q  <= src_hi_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
        end
    end

    // Next-state logic; a register write starts or restarts the copy from any state
    always_comb begin
        state_d   = state_q;
        dma_reg_d = dma_reg_q;
        src_hi_d  = src_hi_q;
        idx_d     = idx_q;
        byte_d    = byte_q;

        case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_SETUP: state_d = ST_RD;
            ST_RD: begin
                byte_d  = iMemData;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            dma_reg_d = iCpuData;
            src_hi_d  = src_hi_remap;
            idx_d     = '0;
            state_d   = ST_SETUP;
        end
    end

    // Bus mux: CPU pass-through unless the DMA owns the bus
    always_comb begin
        oMemAddr   = iCpuAddr;
        oMemData   = iCpuData;
        oMemWe     = iCpuWe && !reg_hit;
        oCpuData   = reg_hit ? dma_reg_q : iMemData;
        oDmaActive = dma_owns_bus;

        if (dma_owns_bus) begin
            oMemWe   = 1'b0;
            oCpuData = reg_hit ? dma_reg_q : OPEN_BUS;
            case (state_q)
                ST_RD: begin
                    oMemAddr = {src_hi_q, idx_q};
                end
                ST_WR: begin
                    oMemAddr = DEST_BASE + 16'(idx_q);
                    oMemData = byte_q;
                    oMemWe   = 1'b1;
                end
                default: begin
                    oMemAddr = iCpuAddr;
                end
            endcase
        end
    end

endmodule
